// File: rtl/vitdec_pkg.sv
// Shared Viterbi-link constants: rate encodings, puncture keep masks, periods.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Contents: RATE_* encodings, KEEP_* masks ({B,A} bit order), PERIOD_* lengths,
//           clear_lowest() helper for draining a pending-symbol mask.
package vitdec_pkg;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;
    localparam logic [1:0] RATE_INV = 2'b11;

    // Keep masks are {B,A}: bit0 keeps the A symbol, bit1 keeps the B symbol.
    localparam logic [1:0] KEEP_NONE = 2'b00;
    localparam logic [1:0] KEEP_A    = 2'b01;
    localparam logic [1:0] KEEP_B    = 2'b10;
    localparam logic [1:0] KEEP_AB   = 2'b11;

    // Number of pairs in one puncture period for each rate.
    localparam logic [1:0] PERIOD_1_2 = 2'd1;
    localparam logic [1:0] PERIOD_2_3 = 2'd2;
    localparam logic [1:0] PERIOD_3_4 = 2'd3;

    // Drop the lowest set bit: A always leaves before B.
    function automatic logic [1:0] clear_lowest(input logic [1:0] p);
        return p & (p - 2'd1);
    endfunction

endpackage

// File: rtl/punct_pattern.sv
// Puncture pattern lookup: (rate, phase) -> keep mask {B,A} and end-of-period flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: rate (2b code), phase (0..2) in; keep (2b mask), period_end out.
module punct_pattern
    import vitdec_pkg::*;
(
    input  logic [1:0] rate,
    input  logic [1:0] phase,
    output logic [1:0] keep,
    output logic       period_end
);

    always_comb begin
        keep       = KEEP_NONE;
        period_end = 1'b1;
        case (rate)
            RATE_1_2: begin
                keep       = KEEP_AB;
                period_end = 1'b1;
            end
            RATE_2_3: begin
                keep       = (phase == 2'd0) ? KEEP_AB : KEEP_A;
                period_end = (phase == PERIOD_2_3 - 2'd1);
            end
            RATE_3_4: begin
                case (phase)
                    2'd0:    keep = KEEP_AB;
                    2'd1:    keep = KEEP_A;
                    default: keep = KEEP_B;
                endcase
                period_end = (phase == PERIOD_3_4 - 2'd1);
            end
            // Invalid rate: swallow the pair and keep the pattern parked at phase 0.
            default: begin
                keep       = KEEP_NONE;
                period_end = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/punct.sv
// Puncturer: serializes encoder (A,B) pairs to one symbol per cycle, deleting per code rate.
// Latency: pair accepted at edge t gives first symbol valid in the following cycle.
// Backpressure: valid/ready both sides; output held stable while stalled, in_ready comb from out_ready.
// Ports: clock, reset_n; coderate; in_a/in_b/in_last/in_valid -> in_ready;
//        out_data/out_last/out_valid <- out_ready.
module punct
    import vitdec_pkg::*;
#(
    parameter int DWIDTH = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        coderate,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DWIDTH-1:0] hold_a;
    logic [DWIDTH-1:0] hold_b;
    logic [1:0]        pend;
    logic [1:0]        phase;
    logic [1:0]        rate_act;
    logic              last_hold;

    logic [1:0]        sel_rate;
    logic [1:0]        keep;
    logic              period_end;
    logic              single;
    logic              accept;
    logic              fire;

    // A new rate is only honoured at a period boundary; mid-period pairs use the latched one.
    assign sel_rate = (phase == 2'd0) ? coderate : rate_act;

    punct_pattern u_pattern (
        .rate       (sel_rate),
        .phase      (phase),
        .keep       (keep),
        .period_end (period_end)
    );

    assign single    = (pend == KEEP_A) || (pend == KEEP_B);
    assign out_valid = |pend;
    assign out_data  = pend[0] ? hold_a : hold_b;
    assign out_last  = last_hold && single;

    // Ready when empty, or when the final pending symbol leaves this cycle: no bubble between pairs.
    assign in_ready = (pend == KEEP_NONE) || (out_ready && single);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_a    <= '0;
            hold_b    <= '0;
            pend      <= KEEP_NONE;
            phase     <= 2'd0;
            rate_act  <= RATE_1_2;
            last_hold <= 1'b0;
        end else begin
            if (accept) begin
                // A load overrides the drain of the last pending symbol in the same cycle.
                hold_a    <= in_a;
                hold_b    <= in_b;
                pend      <= keep;
                last_hold <= in_last;
                phase     <= (period_end || in_last) ? 2'd0 : phase + 2'd1;
                if (phase == 2'd0) begin
                    rate_act <= coderate;
                end
            end else if (fire) begin
                pend <= clear_lowest(pend);
            end
        end
    end

endmodule

// File: tb/tb_punct.sv
// Testbench for punct: directed and random pair streams against a pattern-table reference.
// Latency: n/a.
// Backpressure: out_ready driven always-high, random, or held low depending on the step.
module tb_punct;

    localparam int DW = 8;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [1:0]    coderate = 2'b00;
    logic [DW-1:0] in_a     = '0;
    logic [DW-1:0] in_b     = '0;
    logic          in_last  = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int first_acc = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic [1:0] rate;
    } pair_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         c;
        logic       ir;
    } sym_t;

    pair_t stim[$];
    sym_t  got[$];
    sym_t  exp_q[$];

    logic       stall_prev = 1'b0;
    logic [7:0] stall_d    = '0;
    logic       stall_l    = 1'b0;

    // Symbols kept per position in the puncture period, indexed by rate code.
    string pat [4][3] = '{'{"AB", "AB", "AB"},
                          '{"AB", "A",  "A"},
                          '{"AB", "A",  "B"},
                          '{"",   "",   ""}};
    int    per [4]    = '{1, 2, 3, 1};

    punct #(.DWIDTH(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .coderate  (coderate),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // out_ready generator
    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Output collector and stall-stability monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (stall_prev) begin
                chk("stall valid", {31'd0, out_valid}, 32'd1);
                chk("stall data", {24'd0, out_data}, {24'd0, stall_d});
                chk("stall last", {31'd0, out_last}, {31'd0, stall_l});
            end
            if (out_valid && out_ready)
                got.push_back('{out_data, out_last, cyc, in_ready});
            stall_prev = out_valid && !out_ready;
            stall_d    = out_data;
            stall_l    = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial forever begin
        @(negedge reset_n);
        stall_prev = 1'b0;
    end

    // Reference: walk pairs, latch rate at period start, emit kept symbols.
    task automatic build_expected();
        int         pos = 0;
        logic [1:0] r   = 2'b00;
        string      s;
        logic       ka, kb;
        exp_q.delete();
        foreach (stim[i]) begin
            if (pos == 0) r = stim[i].rate;
            s  = pat[r][pos];
            ka = (s == "AB") || (s == "A");
            kb = (s == "AB") || (s == "B");
            if (ka) exp_q.push_back('{stim[i].a, stim[i].last && !kb, 0, 1'b0});
            if (kb) exp_q.push_back('{stim[i].b, stim[i].last, 0, 1'b0});
            pos = stim[i].last ? 0 : (pos + 1) % per[r];
        end
    endtask

    task automatic drive(input int gap_pct);
        int w;
        foreach (stim[i]) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_a     = stim[i].a;
            in_b     = stim[i].b;
            in_last  = stim[i].last;
            coderate = stim[i].rate;
            w = 0;
            forever begin
                @(negedge clock);
                if (in_ready) break;
                w++;
                if (w > 200) begin
                    failures++;
                    $error("FAIL accept_timeout observed=stuck expected=in_ready");
                    break;
                end
            end
            if (i == 0) first_acc = cyc + 1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run(input string name, input int mode, input int gap_pct);
        int w;
        rdy_mode = mode;
        repeat (2) @(posedge clock);
        #1;
        got.delete();
        build_expected();
        drive(gap_pct);
        w = 0;
        while (got.size() < exp_q.size() && w < 400) begin
            @(posedge clock);
            w++;
        end
        repeat (6) @(posedge clock);
        #1;
        chk({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s data[%0d]", name, i), {24'd0, got[i].d}, {24'd0, exp_q[i].d});
            chk($sformatf("%s last[%0d]", name, i), {31'd0, got[i].l}, {31'd0, exp_q[i].l});
        end
    endtask

    task automatic chk_lit(input string name, input int lit[$]);
        chk({name, " lit count"}, got.size(), lit.size());
        for (int i = 0; i < got.size() && i < lit.size(); i++)
            chk($sformatf("%s lit[%0d]", name, i), {24'd0, got[i].d}, lit[i]);
    endtask

    task automatic chk_back_to_back(input string name);
        if (got.size() > 0) chk({name, " latency"}, got[0].c, first_acc);
        for (int i = 1; i < got.size(); i++)
            chk($sformatf("%s cycle[%0d]", name, i), got[i].c, got[0].c + i);
    endtask

    initial begin
        int lit[$];
        int len;
        logic [1:0] rfr;

        // Reset state
        #12;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_data", {24'd0, out_data}, 32'd0);
        chk("rst out_last", {31'd0, out_last}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Rate 1/2
        stim = '{'{8'd11, 8'd12, 1'b0, 2'b00}, '{8'd21, 8'd22, 1'b1, 2'b00}};
        run("r12", 0, 0);
        lit = '{11, 12, 21, 22};
        chk_lit("r12", lit);
        chk_back_to_back("r12");
        for (int i = 0; i < got.size(); i += 2)
            chk($sformatf("r12 in_ready_on_A[%0d]", i), {31'd0, got[i].ir}, 32'd0);

        // Rate 2/3
        stim = '{'{8'd10, 8'd11, 1'b0, 2'b01}, '{8'd20, 8'd21, 1'b0, 2'b01},
                 '{8'd30, 8'd31, 1'b0, 2'b01}, '{8'd40, 8'd41, 1'b1, 2'b01}};
        run("r23", 0, 0);
        lit = '{10, 11, 20, 30, 31, 40};
        chk_lit("r23", lit);
        chk_back_to_back("r23");

        // Rate 3/4, unstalled then with random backpressure
        stim.delete();
        for (int k = 1; k <= 6; k++)
            stim.push_back('{8'(k * 10), 8'(k * 10 + 1), k == 6, 2'b10});
        run("r34", 0, 0);
        lit = '{10, 11, 20, 31, 40, 41, 50, 61};
        chk_lit("r34", lit);
        chk_back_to_back("r34");
        run("r34 stall", 1, 0);
        chk_lit("r34 stall", lit);

        // Rate change mid-period only takes effect after the wrap
        stim = '{'{8'd10, 8'd11, 1'b0, 2'b10}, '{8'd20, 8'd21, 1'b0, 2'b00},
                 '{8'd30, 8'd31, 1'b0, 2'b00}, '{8'd40, 8'd41, 1'b0, 2'b00},
                 '{8'd50, 8'd51, 1'b1, 2'b00}};
        run("ratechg", 0, 0);
        lit = '{10, 11, 20, 31, 40, 41, 50, 51};
        chk_lit("ratechg", lit);

        // in_last on a phase-1 pair restarts the pattern
        stim = '{'{8'd10, 8'd11, 1'b0, 2'b10}, '{8'd20, 8'd21, 1'b1, 2'b10},
                 '{8'd30, 8'd31, 1'b1, 2'b10}};
        run("midlast", 0, 0);
        lit = '{10, 11, 20, 30, 31};
        chk_lit("midlast", lit);
        if (got.size() > 2) chk("midlast last_on_A", {31'd0, got[2].l}, 32'd1);

        // Invalid rate swallows pairs
        stim = '{'{8'd10, 8'd11, 1'b0, 2'b11}, '{8'd20, 8'd21, 1'b1, 2'b11},
                 '{8'd30, 8'd31, 1'b1, 2'b00}};
        run("rinv", 0, 0);
        lit = '{30, 31};
        chk_lit("rinv", lit);

        // Random frames, random rates, gaps and backpressure
        for (int rep = 0; rep < 3; rep++) begin
            stim.delete();
            for (int f = 0; f < 8; f++) begin
                len = $urandom_range(1, 7);
                rfr = 2'($urandom_range(0, 3));
                for (int k = 0; k < len; k++)
                    stim.push_back('{8'($urandom), 8'($urandom), k == len - 1,
                                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : rfr});
            end
            run($sformatf("rand%0d", rep), (rep == 2) ? 0 : 1, (rep == 1) ? 30 : 0);
        end

        // Asynchronous reset while both symbols are pending
        rdy_mode = 2;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_a     = 8'hA0;
        in_b     = 8'hA1;
        in_last  = 1'b0;
        coderate = 2'b10;
        @(negedge clock);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre-rst in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst out_data", {24'd0, out_data}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        stim = '{'{8'hB0, 8'hB1, 1'b1, 2'b10}};
        run("post-rst", 0, 0);
        lit = '{'hB0, 'hB1};
        chk_lit("post-rst", lit);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
